exec_sequencer: RTL and testbench

Command sequencer for the Executor. It fetches 102-bit command words from a synchronous-read command memory, splits each word into flags and arguments, and issues the command. It then waits for the Executor's ready flag and advances the execution address: sequentially, or by the signed jump offset the Executor returns. It sits between the program memory and the Executor, and owns the program counter, start/halt control and a hang watchdog.

---
 rtl/exec_sequencer.sv | 153 +++++++++++++++
 tb/tb_exec_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: fetches 102-bit command words, issues them to the Executor and
// advances the PC sequentially or by the Executor's signed jump offset.
module exec_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int START_ADDR  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               CLK_,
    input  logic               RST_N_,
    input  logic               START_,
    input  logic               HALT_,
    output logic               MEM_RD_,
    output logic [ADDR_W-1:0]  MEM_ADDR_,
    input  logic [101:0]       MEM_DATA_,
    output logic [5:0]         CMD_FL_,
    output logic [95:0]        CMD_ARG_,
    output logic               CMD_VALID_,
    input  logic               READY_FL_,
    input  logic               JMP_FL_,
    input  logic signed [31:0] NEW_EXEC_ADDR_OFF_,
    output logic [ADDR_W-1:0]  PC_,
    output logic               BUSY_,
    output logic               DONE_,
    output logic               ERR_
);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_UPDATE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [5:0]          r_cmd_fl;
    logic [95:0]         r_cmd_arg;
    logic [CNT_W-1:0]    r_wd_cnt;
    logic                r_jmp;
    logic signed [31:0]  r_off;
    logic                r_halt_pend;
    logic                r_err;
    logic                r_done;
    logic                w_halt_cmd;
    logic                w_timeout;
    logic                w_halt_now;
    logic                w_to_idle;
    logic [ADDR_W-1:0]   w_pc_upd;

    assign w_halt_cmd = (MEM_DATA_[101:96] == 6'b000000);
    assign w_timeout  = !READY_FL_ && (r_wd_cnt == CNT_LAST);
    // A HALT_ arriving in the UPDATE cycle itself must stop the sequencer there
    assign w_halt_now = r_halt_pend || HALT_;
    // Truncating the sum to the PC width gives modulo-2^ADDR_W wrap for negative offsets too
    assign w_pc_upd   = r_jmp ? ADDR_W'(32'(r_pc) + r_off) : r_pc + ADDR_W'(1);

    assign MEM_RD_    = (r_state == S_FETCH);
    assign MEM_ADDR_  = r_pc;
    assign PC_        = r_pc;
    assign CMD_FL_    = r_cmd_fl;
    assign CMD_ARG_   = r_cmd_arg;
    assign CMD_VALID_ = (r_state == S_ISSUE);
    assign BUSY_      = (r_state != S_IDLE);
    assign DONE_      = r_done;
    assign ERR_       = r_err;

    always_ff @(posedge CLK_ or negedge RST_N_) begin
        if (!RST_N_) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_idle   = 1'b0;
        case (r_state)
            S_IDLE:   if (START_) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_halt_cmd) begin
                    w_state_nxt = S_IDLE;
                    w_to_idle   = 1'b1;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (READY_FL_) begin
                    w_state_nxt = S_UPDATE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_to_idle   = 1'b1;
                end
            end
            S_UPDATE: begin
                if (w_halt_now) begin
                    w_state_nxt = S_IDLE;
                    w_to_idle   = 1'b1;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_ or negedge RST_N_) begin
        if (!RST_N_) begin
            r_pc        <= PC_INIT;
            r_cmd_fl    <= '0;
            r_cmd_arg   <= '0;
            r_wd_cnt    <= '0;
            r_jmp       <= 1'b0;
            r_off       <= '0;
            r_halt_pend <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_to_idle;
            case (r_state)
                S_IDLE: begin
                    if (START_) begin
                        r_pc        <= PC_INIT;
                        r_err       <= 1'b0;
                        r_halt_pend <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_cmd_fl  <= MEM_DATA_[101:96];
                    r_cmd_arg <= MEM_DATA_[95:0];
                end
                S_ISSUE:  r_wd_cnt <= '0;
                S_WAIT: begin
                    if (READY_FL_) begin
                        r_jmp <= JMP_FL_;
                        r_off <= NEW_EXEC_ADDR_OFF_;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                S_UPDATE: r_pc <= w_pc_upd;
                default:  ;
            endcase
            // Every exit to IDLE drops a pending halt; HALT_ is only recorded while busy
            if (w_to_idle)
                r_halt_pend <= 1'b0;
            else if ((r_state != S_IDLE) && HALT_)
                r_halt_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: program-level reference model driving a
// command memory and an Executor stub, with directed and randomized programs.
module tb_exec_sequencer;
    localparam int ADDR_W = 8;
    localparam int TMO    = 255;
    localparam int NCMD   = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic               halt = 1'b0;
    logic               ready = 1'b0;
    logic               jmp = 1'b0;
    logic signed [31:0] off = '0;
    logic [101:0]       mem_data = '0;
    logic               MEM_RD_;
    logic [ADDR_W-1:0]  MEM_ADDR_;
    logic [5:0]         CMD_FL_;
    logic [95:0]        CMD_ARG_;
    logic               CMD_VALID_;
    logic [ADDR_W-1:0]  PC_;
    logic               BUSY_;
    logic               DONE_;
    logic               ERR_;

    logic [101:0]       mem [256];
    int                 lat_a [NCMD];
    bit                 jmp_a [NCMD];
    logic [31:0]        off_a [NCMD];
    int                 halt_wait_idx;
    int                 halt_upd_idx;
    int                 rst_idx;
    int                 n_issued;
    int                 n_chk = 0;
    int                 n_pass = 0;
    logic               prev_rd = 1'b0;
    logic [ADDR_W-1:0]  prev_addr = '0;

    exec_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(0), .TIMEOUT_CYC(TMO)) dut (
        .CLK_(clk), .RST_N_(rst_n), .START_(start), .HALT_(halt),
        .MEM_RD_(MEM_RD_), .MEM_ADDR_(MEM_ADDR_), .MEM_DATA_(mem_data),
        .CMD_FL_(CMD_FL_), .CMD_ARG_(CMD_ARG_), .CMD_VALID_(CMD_VALID_),
        .READY_FL_(ready), .JMP_FL_(jmp), .NEW_EXEC_ADDR_OFF_(off),
        .PC_(PC_), .BUSY_(BUSY_), .DONE_(DONE_), .ERR_(ERR_)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    // One clock; the command memory answers one cycle after a read strobe, else garbage
    task automatic step();
        @(posedge clk);
        #1;
        if (prev_rd) mem_data = mem[prev_addr];
        else         mem_data = 102'({$urandom(), $urandom(), $urandom(), $urandom()});
        prev_rd   = MEM_RD_;
        prev_addr = MEM_ADDR_;
    endtask

    task automatic clear_setup();
        for (int a = 0; a < 256; a++) mem[a] = '0;
        for (int i = 0; i < NCMD; i++) begin
            lat_a[i] = 2;
            jmp_a[i] = 1'b0;
            off_a[i] = '0;
        end
        halt_wait_idx = -1;
        halt_upd_idx  = -1;
        rst_idx       = -1;
    endtask

    function automatic logic [101:0] rand_cmd();
        logic [101:0] w;
        w[95:0]   = {$urandom(), $urandom(), $urandom()};
        w[101:96] = 6'($urandom_range(1, 63));
        return w;
    endfunction

    task automatic check_reset_outputs(input string nm);
        check_eq({nm, " busy"}, BUSY_, 0);
        check_eq({nm, " mem_rd"}, MEM_RD_, 0);
        check_eq({nm, " valid"}, CMD_VALID_, 0);
        check_eq({nm, " done"}, DONE_, 0);
        check_eq({nm, " err"}, ERR_, 0);
        check_eq({nm, " pc"}, PC_, 0);
        check_eq({nm, " mem_addr"}, MEM_ADDR_, 0);
        check_eq({nm, " fl"}, CMD_FL_, 0);
        check_eq({nm, " arg"}, CMD_ARG_, 0);
    endtask

    // Executes a program from the loaded memory against the reference model
    task automatic run_prog(input string nm);
        logic [ADDR_W-1:0] pc;
        logic [101:0]      w;
        int                cmd;
        bit                ok;
        pc       = '0;
        cmd      = 0;
        n_issued = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({nm, " err cleared"}, ERR_, 0);
        while (1) begin
            ok = (cmd < NCMD);
            check_eq({nm, " cmd bound"}, ok, 1);
            if (!ok) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                return;
            end
            check_eq({nm, " fetch rd"}, MEM_RD_, 1);
            check_eq({nm, " fetch addr"}, MEM_ADDR_, pc);
            w = mem[pc];
            step();
            ready = 1'($urandom_range(0, 1));
            step();
            ready = 1'b0;
            if (w[101:96] == 6'd0) begin
                check_eq({nm, " halt-cmd done"}, DONE_, 1);
                check_eq({nm, " halt-cmd busy"}, BUSY_, 0);
                check_eq({nm, " halt-cmd pc"}, PC_, pc);
                check_eq({nm, " halt-cmd err"}, ERR_, 0);
                break;
            end
            check_eq({nm, " issue valid"}, CMD_VALID_, 1);
            check_eq({nm, " issue fl"}, CMD_FL_, w[101:96]);
            check_eq({nm, " issue arg"}, CMD_ARG_, w[95:0]);
            if (CMD_VALID_ === 1'b1) n_issued++;
            if (lat_a[cmd] == 0) begin
                for (int k = 1; k <= TMO; k++) begin
                    step();
                    if (k == 1 || k == TMO) check_eq({nm, " wd valid low"}, CMD_VALID_, 0);
                    if (k == TMO) begin
                        check_eq({nm, " wd err before"}, ERR_, 0);
                        check_eq({nm, " wd busy before"}, BUSY_, 1);
                        check_eq({nm, " wd fl held"}, CMD_FL_, w[101:96]);
                    end
                end
                step();
                check_eq({nm, " wd err"}, ERR_, 1);
                check_eq({nm, " wd done"}, DONE_, 1);
                check_eq({nm, " wd busy"}, BUSY_, 0);
                check_eq({nm, " wd pc"}, PC_, pc);
                break;
            end
            for (int k = 1; k <= lat_a[cmd]; k++) begin
                step();
                if (cmd == rst_idx) begin
                    start = 1'b0;
                    #2 rst_n = 1'b0;
                    #1;
                    check_reset_outputs({nm, " async"});
                    @(posedge clk);
                    #1;
                    check_eq({nm, " rst no done"}, DONE_, 0);
                    rst_n = 1'b1;
                    prev_rd = 1'b0;
                    step();
                    check_eq({nm, " post-rst done"}, DONE_, 0);
                    check_eq({nm, " post-rst busy"}, BUSY_, 0);
                    check_eq({nm, " post-rst pc"}, PC_, 0);
                    return;
                end
                check_eq({nm, " wait valid low"}, CMD_VALID_, 0);
                check_eq({nm, " wait fl held"}, CMD_FL_, w[101:96]);
                check_eq({nm, " wait arg held"}, CMD_ARG_, w[95:0]);
                halt  = (cmd == halt_wait_idx) && (k == 1);
                start = 1'($urandom_range(0, 3) == 0);
                if (k == lat_a[cmd]) begin
                    ready = 1'b1;
                    jmp   = jmp_a[cmd];
                    off   = off_a[cmd];
                end
            end
            step();
            ready = 1'($urandom_range(0, 1));
            jmp   = 1'($urandom_range(0, 1));
            off   = $urandom();
            start = 1'b0;
            halt  = (cmd == halt_upd_idx);
            pc = jmp_a[cmd] ? pc + off_a[cmd][ADDR_W-1:0] : pc + 8'd1;
            step();
            halt  = 1'b0;
            ready = 1'b0;
            if (cmd == halt_wait_idx || cmd == halt_upd_idx) begin
                check_eq({nm, " halt done"}, DONE_, 1);
                check_eq({nm, " halt busy"}, BUSY_, 0);
                check_eq({nm, " halt pc"}, PC_, pc);
                check_eq({nm, " halt no fetch"}, MEM_RD_, 0);
                break;
            end
            cmd++;
        end
        step();
        check_eq({nm, " done one-cycle"}, DONE_, 0);
        check_eq({nm, " idle no fetch"}, MEM_RD_, 0);
    endtask

    initial begin
        clear_setup();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        clear_setup();
        for (int a = 0; a < 3; a++) mem[a] = {6'b100000, 96'($urandom())};
        run_prog("linear");
        check_eq("linear valid count", n_issued, 3);
        check_eq("linear final pc", PC_, 3);

        clear_setup();
        mem[0]   = {6'b100000, 96'h00000FFF00000FFF00200189};
        lat_a[0] = 3;
        run_prog("args");

        clear_setup();
        mem[0]   = rand_cmd(); jmp_a[0] = 1'b1; off_a[0] = 32'd5;
        mem[5]   = rand_cmd(); jmp_a[1] = 1'b1; off_a[1] = 32'hFFFFFFFE;
        mem[3]   = rand_cmd(); jmp_a[2] = 1'b1; off_a[2] = 32'd247;
        mem[250] = rand_cmd(); jmp_a[3] = 1'b1; off_a[3] = 32'd10;
        run_prog("jump");
        check_eq("jump final pc", PC_, 4);

        clear_setup();
        mem[0]   = rand_cmd();
        lat_a[0] = 0;
        run_prog("watchdog");
        repeat (3) step();
        check_eq("watchdog err sticky", ERR_, 1);
        clear_setup();
        mem[0] = rand_cmd();
        run_prog("restart");
        check_eq("restart err", ERR_, 0);

        clear_setup();
        for (int a = 0; a < 6; a++) mem[a] = rand_cmd();
        halt_wait_idx = 1;
        run_prog("halt_wait");

        clear_setup();
        for (int a = 0; a < 6; a++) mem[a] = rand_cmd();
        halt_upd_idx = 0;
        run_prog("halt_update");

        clear_setup();
        mem[0] = rand_cmd(); jmp_a[0] = 1'b1; off_a[0] = 32'd7;
        mem[7] = rand_cmd();
        rst_idx = 1;
        run_prog("reset_wait");

        for (int r = 0; r < 20; r++) begin
            clear_setup();
            for (int a = 0; a < 256; a++)
                mem[a] = ($urandom_range(0, 9) == 0) ? 102'd0 : rand_cmd();
            for (int i = 0; i < NCMD; i++) begin
                lat_a[i] = $urandom_range(1, 4);
                jmp_a[i] = 1'($urandom_range(0, 1));
                off_a[i] = $urandom();
            end
            if ($urandom_range(0, 1) == 1) halt_wait_idx = $urandom_range(0, 7);
            else                           halt_upd_idx  = $urandom_range(0, 7);
            run_prog("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
